uart_rx_fifo_param: RTL and testbench

//  Parametrised UART receiver: oversampled start detection, configurable data/stop bits.

---
 rtl/uart_rx_fifo_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_param.sv
// Purpose: oversampled UART receiver feeding a first-word-fall-through RX FIFO.
// Latency: byte visible on rd_data one cycle after the final stop-bit sample (+2 cycles sync).
// Backpressure: none on the line; a good frame arriving while the FIFO is full is dropped with overrun_err.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between data and stop bits.
module uart_rx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          sample_clk,
  input  logic                          rstn,
  input  logic                          serial_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err
);

  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic                 line_ok, line_ok_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 stop_bad, stop_bad_n;
  logic                 at_centre;
  logic                 eval_vld, eval_frame_bad;
  logic                 par_bad;
  logic                 good, full, push, pop, ovr;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  assign at_centre = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_n;
  // Parity expectation: even parity unless PARITY_ODD, checked only on frames with good stop bits.
  assign par_bad = eval_vld && !eval_frame_bad &&
                   (par_bit != ((^shift_reg) ^ (PARITY_ODD != 0)));
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign par_bad = 1'b0;
`endif

  // Receiver state and datapath registers.
  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_bad  <= 1'b0;
      line_ok   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      stop_bad  <= stop_bad_n;
      line_ok   <= line_ok_n;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_n;
`endif
    end
  end

  // Next-state logic: start qualification, centre sampling of each bit, frame evaluation.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    bit_cnt_n      = bit_cnt;
    shift_n        = shift_reg;
    stop_bad_n     = stop_bad;
    line_ok_n      = line_ok;
    eval_vld       = 1'b0;
    eval_frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n          = par_bit;
`endif
    case (state)
      S_IDLE: begin
        // A line held low after a framing error must go high before a new start counts.
        if (rx_s) begin
          line_ok_n = 1'b1;
        end else if (line_ok) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end else if (cnt == CNT_HALF) begin
          state_n   = S_DATA;
          cnt_n     = '0;
          bit_cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (at_centre) begin
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          cnt_n   = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n  = '0;
            stop_bad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_n    = S_PARITY;
`else
            state_n    = S_STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_centre) begin
          par_n   = rx_s;
          cnt_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (at_centre) begin
          cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            eval_vld       = 1'b1;
            eval_frame_bad = stop_bad | ~rx_s;
            state_n        = S_IDLE;
            bit_cnt_n      = '0;
            if (eval_frame_bad) line_ok_n = 1'b0;
          end else begin
            stop_bad_n = stop_bad | ~rx_s;
            bit_cnt_n  = bit_cnt + BW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A pop in the evaluation cycle frees a slot, so a full FIFO can still accept the frame.
  assign pop  = rd_en && (fifo_count != '0);
  assign full = (fifo_count == FULL_CNT);
  assign good = eval_vld && !eval_frame_bad && !par_bad;
  assign push = good && (!full || pop);
  assign ovr  = good && full && !pop;

  // FIFO storage; contents need no reset because rd_data is gated by rd_valid.
  always_ff @(posedge sample_clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Registered single-cycle error pulses, at most one per frame.
  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= eval_vld && eval_frame_bad;
      overrun_err <= ovr;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, registered like the others.
  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) parity_err <= 1'b0;
    else       parity_err <= par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed plus randomized bench for uart_rx_fifo_param with a queue-based reference model.
module tb_uart_rx_fifo_param;
  localparam int DB = 8;
  localparam int OS = 8;
  localparam int SB = 1;
  localparam int D  = 4;
  localparam int PO = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          sample_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          serial_in = 1'b1;
  logic          rd_en = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rd_valid;
  logic [$clog2(D):0] fifo_count;
  logic          frame_err, parity_err, overrun_err;

  uart_rx_fifo_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB),
                       .FIFO_DEPTH(D), .PARITY_ODD(PO)) dut (
    .sample_clk(sample_clk), .rstn(rstn), .serial_in(serial_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err));

  always #5 sample_clk = ~sample_clk;

  int cmp_n = 0;
  int bad_n = 0;
  int fe_seen = 0, pe_seen = 0, ov_seen = 0;
  int fe_exp = 0, pe_exp = 0, ov_exp = 0;
  logic [DB-1:0] q[$];

  // Count cycles each error output is high; a single-cycle pulse per event keeps these equal to the model.
  always @(negedge sample_clk) begin
    if (frame_err)   fe_seen++;
    if (parity_err)  pe_seen++;
    if (overrun_err) ov_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DB-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, " rd_valid"},   32'(rd_valid),   32'(q.size() != 0));
    chk({tag, " rd_data"},    32'(rd_data),    32'(head));
    chk({tag, " frame_err"},  32'(fe_seen),    32'(fe_exp));
    chk({tag, " parity_err"}, 32'(pe_seen),    32'(pe_exp));
    chk({tag, " overrun"},    32'(ov_seen),    32'(ov_exp));
  endtask

  // Reference: a frame is judged on stop bits, then parity, then room in the FIFO.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v, input bit pop);
    bit par_ok;
    bit was_full;
    par_ok   = (PB == 0) || (par_v == ((^d) ^ (PO != 0)));
    was_full = (q.size() == D);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (!stop_v)                 fe_exp++;
    else if (!par_ok)            pe_exp++;
    else if (was_full && !pop)   ov_exp++;
    else                         q.push_back(d);
  endtask

  // Drive one frame; optionally pop in the cycle the last stop bit is judged, or cut the frame short.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v,
                            input bit pop_at_eval, input int cut, input int tail_low);
    int nb, eval_off, b;
    nb       = 1 + DB + PB + SB;
    eval_off = 3 + OS / 2 + OS * (DB + PB + SB);
    for (int cyc = 0; cyc < nb * OS; cyc++) begin
      if (cyc >= cut) return;
      @(posedge sample_clk); #1;
      b = cyc / OS;
      if (b == 0)                   serial_in = 1'b0;
      else if (b <= DB)             serial_in = d[b-1];
      else if (PB == 1 && b == DB + 1) serial_in = par_v;
      else                          serial_in = stop_v;
      rd_en = pop_at_eval && (cyc == eval_off - 1);
      if (rd_en) chk("pop-at-eval head", 32'(rd_data), 32'((q.size() != 0) ? q[0] : '0));
    end
    for (int i = 0; i < tail_low; i++) begin
      @(posedge sample_clk); #1;
      rd_en = 1'b0;
      serial_in = 1'b0;
    end
    @(posedge sample_clk); #1;
    rd_en = 1'b0;
    serial_in = 1'b1;
    repeat (2 * OS) @(posedge sample_clk);
    #1;
    model_frame(d, stop_v, par_v, pop_at_eval);
  endtask

  task automatic pop_one();
    @(posedge sample_clk); #1;
    if (q.size() != 0) chk("pop head", 32'(rd_data), 32'(q[0]));
    rd_en = 1'b1;
    @(posedge sample_clk); #1;
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic glitch(input int low_cycles);
    @(posedge sample_clk); #1;
    serial_in = 1'b0;
    repeat (low_cycles) @(posedge sample_clk);
    #1;
    serial_in = 1'b1;
    repeat (3 * OS) @(posedge sample_clk);
    #1;
  endtask

  initial begin
    logic [DB-1:0] rd;
    logic sv, pv;

    // Reset state.
    repeat (3) @(posedge sample_clk);
    #1;
    check_state("reset");
    rstn = 1'b1;
    repeat (4) @(posedge sample_clk);
    #1;

    // Single frame then one pop.
    send_frame(8'hA5, 1'b1, ~(^8'hA5), 1'b0, 1 << 30, 0);
    check_state("frame A5");
    pop_one();
    check_state("after pop A5");

    // rd_en on an empty FIFO changes nothing.
    pop_one();
    check_state("pop empty");

    // Short low pulses on an idle line.
    glitch(2);
    check_state("glitch 2");
    glitch(3);
    check_state("glitch 3");

    // Framing error, line held low afterwards, then a good frame.
    send_frame(8'h3C, 1'b0, ~(^8'h3C), 1'b0, 1 << 30, 2 * OS);
    check_state("frame err 3C");
    send_frame(8'h11, 1'b1, ~(^8'h11), 1'b0, 1 << 30, 0);
    check_state("after ferr 11");
    pop_one();

    // Fill past capacity, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      rd = 8'(i);
      send_frame(rd, 1'b1, ~(^rd), 1'b0, 1 << 30, 0);
    end
    check_state("overrun fill");
    for (int i = 0; i < 4; i++) pop_one();
    check_state("overrun drain");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch drops the frame; correct parity is accepted.
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1 << 30, 0);
    check_state("parity bad 07");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1 << 30, 0);
    check_state("parity good 07");
    pop_one();
`endif

    // Full FIFO with a pop in the completion cycle: no overrun.
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'b1, ~(^rd), 1'b0, 1 << 30, 0);
    end
    check_state("refill");
    send_frame(8'hC3, 1'b1, ~(^8'hC3), 1'b1, 1 << 30, 0);
    check_state("full pop+push");
    for (int i = 0; i < 4; i++) pop_one();
    check_state("drain2");

    // Reset during data bit 4 discards frame and FIFO.
    send_frame(8'h99, 1'b1, ~(^8'h99), 1'b0, 1 << 30, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, OS * 5 + OS / 2, 0);
    rstn = 1'b0;
    serial_in = 1'b1;
    #1;
    q.delete();
    check_state("mid-frame reset");
    repeat (3) @(posedge sample_clk);
    #1;
    rstn = 1'b1;
    repeat (4) @(posedge sample_clk);
    #1;
    send_frame(8'h5A, 1'b1, ~(^8'h5A), 1'b0, 1 << 30, 0);
    check_state("after reset 5A");

    // Randomized frames with occasional bad stop/parity bits and random reads.
    for (int n = 0; n < 14; n++) begin
      rd = 8'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      pv = ~(^rd) ^ 1'b1 ^ 1'b1;
      pv = (^rd) ^ (PO != 0);
      if (PB == 1 && $urandom_range(0, 4) == 0) pv = ~pv;
      send_frame(rd, sv, pv, ($urandom_range(0, 3) == 0), 1 << 30, sv ? 0 : OS);
      check_state("random frame");
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_one();
      check_state("random pops");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
